// File: rtl/approx_error_sweep_ctrl.sv
// Exhaustive sweep sequencer: drives every input vector to an exact/approximate circuit pair
// and accumulates max |exact-approx|, violation count and first failing vector.
//
// state | meaning
// IDLE  | waiting for start; results from last sweep held
// RUN   | stepping vectors, sampling once per SETTLE cycles
// DONE  | one-cycle completion pulse; pass reflects the full sweep
module approx_error_sweep_ctrl #(
  parameter int N_IN   = 4,
  parameter int N_OUT  = 3,
  parameter int SETTLE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [N_OUT-1:0]  et_thr,
  output logic [N_IN-1:0]   vec_out,
  input  logic [N_OUT-1:0]  exact_in,
  input  logic [N_OUT-1:0]  approx_in,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic              pass,
  output logic [N_OUT-1:0]  max_err,
  output logic [N_IN:0]     viol_cnt,
  output logic              fail_valid,
  output logic [N_IN-1:0]   first_fail_vec
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0]   SETTLE_RELOAD = CW'(SETTLE - 1);
  localparam logic [N_IN-1:0] LAST_VEC      = '1;

  state_t             state, state_nxt;
  logic [CW-1:0]      settle_cnt;
  logic [N_OUT-1:0]   et_reg;
  logic [N_OUT-1:0]   err;
  logic               start_ok;
  logic               sample;
  logic               is_viol;

  assign start_ok = (state == IDLE) && start;
  // Abort takes priority over a sample due on the same edge, so that sample is dropped.
  assign sample   = (state == RUN) && !abort && (settle_cnt == '0);
  assign err      = (exact_in >= approx_in) ? (exact_in - approx_in) : (approx_in - exact_in);
  assign is_viol  = err > et_reg;
  assign busy     = (state == RUN);
  assign done     = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        if (abort)                               state_nxt = IDLE;
        else if (sample && (vec_out == LAST_VEC)) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_out        <= '0;
      settle_cnt     <= '0;
      et_reg         <= '0;
      aborted        <= 1'b0;
      pass           <= 1'b0;
      max_err        <= '0;
      viol_cnt       <= '0;
      fail_valid     <= 1'b0;
      first_fail_vec <= '0;
    end else begin
      aborted <= 1'b0;
      if (start_ok) begin
        vec_out        <= '0;
        settle_cnt     <= SETTLE_RELOAD;
        et_reg         <= et_thr;
        pass           <= 1'b0;
        max_err        <= '0;
        viol_cnt       <= '0;
        fail_valid     <= 1'b0;
        first_fail_vec <= '0;
      end else if (state == RUN) begin
        if (abort) begin
          aborted <= 1'b1;
        end else if (sample) begin
          settle_cnt <= SETTLE_RELOAD;
          if (vec_out != LAST_VEC) vec_out <= vec_out + 1'b1;
          if (err > max_err) max_err <= err;
          if (is_viol) begin
            viol_cnt <= viol_cnt + 1'b1;
            if (!fail_valid) begin
              first_fail_vec <= vec_out;
              fail_valid     <= 1'b1;
            end
          end
          // Pass must include the final sample, so it is resolved on the last-vector edge.
          if (vec_out == LAST_VEC) pass <= !is_viol && (viol_cnt == '0);
        end else begin
          settle_cnt <= settle_cnt - 1'b1;
        end
      end
    end
  end

endmodule
